// File: rtl/rgb_led_ctrl.sv
// Multi-channel LED controller: per-channel OFF / ON / BLINK / BLINK_DIM modes
// driven by a shared PWM counter and a millisecond tick.
module rgb_led_ctrl #(
  parameter int CLK_HZ   = 20000000,
  parameter int NUM_CH   = 3,
  parameter int PWM_BITS = 8,
  parameter int PER_BITS = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  input  logic [PER_BITS-1:0] cfg_period,
  output logic [NUM_CH-1:0]   led,
  output logic                tick_ms
);

  localparam int DIV   = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 2;
  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;

  logic [PRE_W-1:0]    r_pre;
  logic                r_tick;
  logic [PWM_BITS-1:0] r_pwm;
  logic [NUM_CH-1:0]   r_led;
  logic [NUM_CH-1:0]   w_led_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
      r_pwm  <= '0;
    end else begin
      if (r_pre == PRE_MAX) r_pre <= '0;
      else                  r_pre <= r_pre + PRE_W'(1);
      r_tick <= (r_pre == PRE_MAX);
      r_pwm  <= r_pwm + PWM_BITS'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [1:0]          r_mode;
    logic [PWM_BITS-1:0] r_duty;
    logic [PER_BITS-1:0] r_per;
    logic [PER_BITS-1:0] r_ms;
    logic                r_phase;
    logic                w_wr;
    logic [PER_BITS-1:0] w_lim;
    logic                w_pwm_on;

    // Out-of-range channel indices never match, so such writes are dropped.
    assign w_wr     = cfg_we && (cfg_ch == CH_W'(c));
    assign w_lim    = (r_per == '0) ? '0 : r_per - PER_BITS'(1);
    assign w_pwm_on = (r_duty == '1) || (r_pwm < r_duty);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mode  <= MODE_OFF;
        r_duty  <= '0;
        r_per   <= '0;
        r_ms    <= '0;
        r_phase <= 1'b1;
      end else if (w_wr) begin
        r_mode  <= cfg_mode;
        r_duty  <= cfg_duty;
        r_per   <= cfg_period;
        r_ms    <= '0;
        r_phase <= 1'b1;
      end else if (r_mode[1]) begin
        if (r_tick) begin
          if (r_ms == w_lim) begin
            r_ms    <= '0;
            r_phase <= ~r_phase;
          end else begin
            r_ms <= r_ms + PER_BITS'(1);
          end
        end
      end else begin
        r_ms    <= '0;
        r_phase <= 1'b1;
      end
    end

    assign w_led_nxt[c] = (r_mode == MODE_OFF)   ? 1'b0 :
                          (r_mode == MODE_ON)    ? w_pwm_on :
                          (r_mode == MODE_BLINK) ? r_phase :
                                                   (r_phase & w_pwm_on);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_led <= '0;
    else        r_led <= w_led_nxt;
  end

  assign led     = r_led;
  assign tick_ms = r_tick;

endmodule

// File: doc/rgb_led_ctrl.md
# rgb_led_ctrl

Parametrised multi-channel LED controller. It supersedes the single fixed "LED on" / blink counter logic. Each channel has a runtime-programmable mode: off, steady on, blink, or blink with PWM dimming, plus an 8-bit brightness duty and a millisecond blink half-period. It sits between the board clock and the RGB LED pins, and a small config write port drives it from top-level logic or a soft controller.

## Interface
Parameters:
- CLK_HZ, 20000000: input clock frequency in Hz; millisecond prescale = CLK_HZ/1000.
- NUM_CH, 3: number of LED channels (red, green, blue by default).
- PWM_BITS, 8: width of the brightness duty and PWM counter.
- PER_BITS, 16: width of the blink half-period in milliseconds.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel index.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BLINK_DIM.
- cfg_duty  in  PWM_BITS  brightness; all-ones = 100 %.
- cfg_period  in  PER_BITS  blink half-period in ms; 0 treated as 1.
- led  out  NUM_CH  LED drive, active-high, registered.
- tick_ms  out  1  one-cycle pulse every millisecond, registered.

## Operation
- Prescaler: counts 0..CLK_HZ/1000-1 and wraps. tick_ms=1 for the one cycle after the counter wraps.
- PWM counter: free-running, PWM_BITS wide, shared by all channels, wraps 2^PWM_BITS-1 -> 0.
- pwm_on[c] = (duty[c] == all-ones) | (pwm_cnt < duty[c]). A duty of 0 gives always dark.
- Per-channel state: mode, duty, period, ms counter, phase bit.
- Blink: on each tick_ms, a channel in mode 2/3 increments its ms counter. When the counter reaches max(period,1)-1 it clears to 0 and phase toggles. In mode 0/1 the ms counter holds at 0 and phase holds at 1.
- Output per channel:
  - OFF -> 0.
  - ON -> pwm_on.
  - BLINK -> phase (full brightness; duty ignored).
  - BLINK_DIM -> phase & pwm_on.
- Config write:
  - When cfg_we=1 and cfg_ch < NUM_CH, the channel latches mode, duty and period, clears its ms counter and sets phase=1 (blink starts lit).
  - cfg_ch >= NUM_CH: the write is ignored with no side effects.
- A write and an expiry on the same channel in the same cycle: the write wins, so the counter clears and phase=1.
- A write on one channel does not disturb other channels, the prescaler or the PWM counter.

## Timing
- Reset (async assert, sync release on clk):
  - led=0, tick_ms=0.
  - All modes OFF, duty=0, period=0, phase=1.
  - Prescaler, PWM and ms counters = 0.
- Reset asserted mid-operation clears all state immediately, with led low within the same cycle (async path).
- Config latency: a write sampled at edge N updates state at N. led reflects the new config after edge N+1.
- tick_ms is high during the cycle after the prescaler wrap edge.
- Blink phase toggles on the edge where tick_ms=1 and the counter equals max(period,1)-1. led follows one edge later.
- Blink full period = 2*max(period,1) ms, exact to ±0 cycles relative to tick_ms.
- PWM period = 2^PWM_BITS clocks. The high time per period is duty clocks, or the full period at all-ones.

## Test plan
- Reset: hold rst_n=0, then release -> led=0, tick_ms=0. With CLK_HZ=10000, tick_ms pulses every 10 clocks, first pulse on cycle 10 after release.
- ON/PWM: ch0 mode=1, duty=64, PWM_BITS=8 -> led[0] high exactly 64 of every 256 clocks. duty=255 -> constantly high. duty=0 -> constantly low.
- BLINK: ch1 mode=2, period=3, CLK_HZ=10000 -> led[1] high 30 clocks, low 30 clocks, repeating, starting high one clock after the write. period=0 -> toggles every tick (10 clocks).
- BLINK_DIM: ch2 mode=3, duty=128, period=2 -> during the lit phase led[2] matches pwm_cnt<128; during the dark phase it stays 0.
- Boundaries:
  - Rewrite ch1 on the exact cycle of its phase expiry -> phase=1 and counter=0, so no toggle is lost or doubled.
  - Write with cfg_ch=3 (NUM_CH=3) -> all outputs unchanged.
- Reset mid-blink: assert rst_n=0 while led=3'b111 -> led=0 immediately. After release all channels are OFF until reconfigured.
